// File: rtl/sram_sprite_reader.sv
// Fetches packed sprite words from SRAM and streams them out as COLOR_WIDTH-bit pixels.
// Pixels leave LSB-nibble first; each new word is fetched only after the previous one is drained.
module sram_sprite_reader #(
    parameter int COLOR_WIDTH     = 4,
    parameter int SRAM_DATA_WIDTH = 16,
    parameter int SRAM_ADDR_WIDTH = 20,
    parameter int PIX_CNT_WIDTH   = 16,
    parameter int RD_LAT          = 2
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_start,
    input  logic [SRAM_ADDR_WIDTH-1:0] i_base_addr,
    input  logic [PIX_CNT_WIDTH-1:0]   i_pixel_count,
    output logic                       o_sram_rd,
    output logic [SRAM_ADDR_WIDTH-1:0] o_sram_addr,
    input  logic [SRAM_DATA_WIDTH-1:0] i_sram_rdata,
    output logic                       o_pixel_valid,
    input  logic                       i_pixel_ready,
    output logic [COLOR_WIDTH-1:0]     o_color,
    output logic [PIX_CNT_WIDTH-1:0]   o_pixel_index,
    output logic                       o_busy,
    output logic                       o_done,
    output logic [2:0]                 o_dbg_state
);

    localparam int PIX_PER_WORD = SRAM_DATA_WIDTH / COLOR_WIDTH;
    localparam int SHIFT        = $clog2(PIX_PER_WORD);
    localparam int WCNT_W       = $clog2(RD_LAT + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READ   = 3'd1,
        WAIT   = 3'd2,
        UNPACK = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t                     state, state_next;
    logic [SRAM_ADDR_WIDTH-1:0] base_r;
    logic [SRAM_ADDR_WIDTH-1:0] addr_r;
    logic [PIX_CNT_WIDTH-1:0]   count_r;
    logic [PIX_CNT_WIDTH-1:0]   idx_r;
    logic [PIX_CNT_WIDTH-1:0]   idx_inc;
    logic [SRAM_DATA_WIDTH-1:0] shift_r;
    logic [WCNT_W-1:0]          wait_cnt;
    logic                       data_due;

    assign idx_inc  = idx_r + 1'b1;
    assign data_due = (wait_cnt == WCNT_W'(RD_LAT));

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next    = state;
        o_sram_rd     = 1'b0;
        o_pixel_valid = 1'b0;
        o_busy        = 1'b0;
        o_done        = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) state_next = (i_pixel_count == '0) ? DONE : READ;
            end
            READ: begin
                o_sram_rd  = 1'b1;
                o_busy     = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                o_sram_rd = 1'b1;
                o_busy    = 1'b1;
                if (data_due) state_next = UNPACK;
            end
            UNPACK: begin
                o_pixel_valid = 1'b1;
                o_busy        = 1'b1;
                if (i_pixel_ready) begin
                    if (idx_inc == count_r)              state_next = DONE;
                    else if (idx_inc[SHIFT-1:0] == '0)   state_next = READ;
                end
            end
            DONE: begin
                o_done     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The strobe stays high through WAIT, so the address register must not move until UNPACK.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            base_r   <= '0;
            addr_r   <= '0;
            count_r  <= '0;
            idx_r    <= '0;
            shift_r  <= '0;
            wait_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        base_r  <= i_base_addr;
                        addr_r  <= i_base_addr;
                        count_r <= i_pixel_count;
                        idx_r   <= '0;
                    end
                end
                READ: wait_cnt <= WCNT_W'(1);
                WAIT: begin
                    if (data_due) shift_r  <= i_sram_rdata;
                    else          wait_cnt <= wait_cnt + 1'b1;
                end
                UNPACK: begin
                    if (i_pixel_ready) begin
                        shift_r <= shift_r >> COLOR_WIDTH;
                        idx_r   <= idx_inc;
                        if (idx_inc[SHIFT-1:0] == '0)
                            addr_r <= base_r + SRAM_ADDR_WIDTH'(idx_inc >> SHIFT);
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_sram_addr   = addr_r;
    assign o_color       = shift_r[COLOR_WIDTH-1:0];
    assign o_pixel_index = idx_r;
    assign o_dbg_state   = state;

endmodule

// File: tb/tb_sram_sprite_reader.sv
// Randomized bench for sram_sprite_reader: latency-accurate SRAM model, pixel/address scoreboards
// derived from the word-by-word packing rule, plus directed boundary and abort scenarios.
module tb_sram_sprite_reader;

    localparam int CW  = 4;
    localparam int DW  = 16;
    localparam int AW  = 20;
    localparam int PW  = 16;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          i_rst, i_start, i_pixel_ready;
    logic [AW-1:0] i_base_addr;
    logic [PW-1:0] i_pixel_count;
    logic          o_sram_rd, o_pixel_valid, o_busy, o_done;
    logic [AW-1:0] o_sram_addr;
    logic [DW-1:0] i_sram_rdata;
    logic [CW-1:0] o_color;
    logic [PW-1:0] o_pixel_index;
    logic [2:0]    o_dbg_state;

    sram_sprite_reader #(
        .COLOR_WIDTH(CW), .SRAM_DATA_WIDTH(DW), .SRAM_ADDR_WIDTH(AW),
        .PIX_CNT_WIDTH(PW), .RD_LAT(LAT)
    ) dut (
        .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_base_addr(i_base_addr),
        .i_pixel_count(i_pixel_count), .o_sram_rd(o_sram_rd), .o_sram_addr(o_sram_addr),
        .i_sram_rdata(i_sram_rdata), .o_pixel_valid(o_pixel_valid),
        .i_pixel_ready(i_pixel_ready), .o_color(o_color), .o_pixel_index(o_pixel_index),
        .o_busy(o_busy), .o_done(o_done), .o_dbg_state(o_dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // SRAM model: data only becomes valid after LAT cycles of continuous strobe.
    logic [DW-1:0] mem [logic [AW-1:0]];
    logic [DW-1:0] junk;
    int            rd_run = 0;

    function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
        return mem.exists(a) ? mem[a] : '0;
    endfunction

    always @(posedge clk) begin
        rd_run <= o_sram_rd ? rd_run + 1 : 0;
        junk   <= DW'($urandom);
    end

    assign i_sram_rdata = (o_sram_rd && rd_run == LAT) ? mem_rd(o_sram_addr) : junk;

    // Ready driver: 0 always ready, 1 random, 2 repeating 1,0,0.
    int ready_mode = 0;
    int ready_phase = 0;
    initial begin
        i_pixel_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: i_pixel_ready = 1'b1;
                1: i_pixel_ready = 1'($urandom_range(0, 1));
                default: begin
                    i_pixel_ready = (ready_phase == 0);
                    ready_phase   = (ready_phase == 2) ? 0 : ready_phase + 1;
                end
            endcase
        end
    end

    // Scoreboards: expected {index, colour} per pixel and one address per word fetch.
    logic [PW+CW-1:0] exp_q[$];
    logic [AW-1:0]    exp_addr_q[$];
    logic [AW-1:0]    cur_addr = '0;
    bit               mon_en = 1'b0;
    bit               prev_rd = 1'b0;
    bit               rd_seen = 1'b0;
    int               done_cnt = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (o_sram_rd) begin
                rd_seen = 1'b1;
                if (!prev_rd) begin
                    if (exp_addr_q.size() == 0) check("addr_unexpected", 32'(exp_addr_q.size()), 32'd1);
                    else cur_addr = exp_addr_q.pop_front();
                end
                check("sram_addr", 32'(o_sram_addr), 32'(cur_addr));
            end
            if (o_pixel_valid) begin
                if (exp_q.size() == 0) check("pixel_unexpected", 32'(exp_q.size()), 32'd1);
                else begin
                    check("pixel_idx_color", 32'({o_pixel_index, o_color}), 32'(exp_q[0]));
                    if (i_pixel_ready) void'(exp_q.pop_front());
                end
            end
        end
        if (o_done) done_cnt++;
        prev_rd = o_sram_rd;
    end

    function automatic int words_of(input int cnt);
        return (cnt + 3) / 4;
    endfunction

    task automatic fill_mem(input logic [AW-1:0] base, input int cnt);
        for (int w = 0; w < words_of(cnt); w++) mem[base + AW'(w)] = DW'($urandom);
    endtask

    task automatic build_expect(input logic [AW-1:0] base, input int cnt);
        logic [DW-1:0] word;
        exp_q.delete();
        exp_addr_q.delete();
        for (int w = 0; w < words_of(cnt); w++) exp_addr_q.push_back(base + AW'(w));
        for (int i = 0; i < cnt; i++) begin
            word = mem_rd(base + AW'(i / 4));
            exp_q.push_back({PW'(i), CW'(word >> (4 * (i % 4)))});
        end
    endtask

    task automatic run_job(input logic [AW-1:0] base, input int cnt, input int mode, input bit inject);
        int cycles;
        bit got;
        build_expect(base, cnt);
        ready_mode  = mode;
        ready_phase = 0;
        done_cnt    = 0;
        rd_seen     = 1'b0;
        mon_en      = 1'b1;
        @(posedge clk); #1;
        i_base_addr   = base;
        i_pixel_count = PW'(cnt);
        i_start       = 1'b1;
        @(posedge clk); #1;
        i_start       = 1'b0;
        i_base_addr   = AW'($urandom);
        i_pixel_count = PW'($urandom);
        @(negedge clk);
        check("busy_after_start", 32'(o_busy), 32'(cnt != 0));
        cycles = 1;
        got    = 1'b0;
        while (!got && cycles < 4000) begin
            if (o_done) got = 1'b1;
            else begin
                if (inject && cycles == 6) begin
                    i_start       = 1'b1;
                    i_base_addr   = 20'h3_0000;
                    i_pixel_count = 16'd2;
                end else i_start = 1'b0;
                @(negedge clk);
                cycles++;
            end
        end
        i_start = 1'b0;
        check("done_seen", 32'(got), 32'd1);
        if (got) begin
            check("busy_in_done", 32'(o_busy), 32'd0);
            check("valid_in_done", 32'(o_pixel_valid), 32'd0);
            if (mode == 0) check("latency", 32'(cycles), 32'(1 + words_of(cnt) * (LAT + 1) + cnt));
        end
        @(negedge clk);
        check("done_one_cycle", 32'(o_done), 32'd0);
        check("done_count", 32'(done_cnt), 32'd1);
        check("pixels_left", 32'(exp_q.size()), 32'd0);
        check("fetches_left", 32'(exp_addr_q.size()), 32'd0);
        if (cnt == 0) check("no_sram_rd", 32'(rd_seen), 32'd0);
        mon_en = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rd"}, 32'(o_sram_rd), 32'd0);
        check({tag, "_addr"}, 32'(o_sram_addr), 32'd0);
        check({tag, "_valid"}, 32'(o_pixel_valid), 32'd0);
        check({tag, "_color"}, 32'(o_color), 32'd0);
        check({tag, "_index"}, 32'(o_pixel_index), 32'd0);
        check({tag, "_busy"}, 32'(o_busy), 32'd0);
        check({tag, "_done"}, 32'(o_done), 32'd0);
    endtask

    initial begin
        bit found;
        logic [AW-1:0] rb;
        i_rst         = 1'b1;
        i_start       = 1'b0;
        i_base_addr   = '0;
        i_pixel_count = '0;
        repeat (3) @(posedge clk);
        #1 i_rst = 1'b0;
        @(negedge clk);
        check_outputs_zero("reset");

        // Reference stream 1,2,3,4,A,B; nibbles C,D must be dropped.
        mem[20'h100] = 16'h4321;
        mem[20'h101] = 16'hDCBA;
        run_job(20'h100, 6, 0, 1'b0);

        run_job(20'h040, 0, 0, 1'b0);

        fill_mem(20'h2000, 4);
        run_job(20'h2000, 4, 2, 1'b0);

        fill_mem(20'hFFFFF, 8);
        run_job(20'hFFFFF, 8, 0, 1'b0);

        fill_mem(20'h0500, 8);
        run_job(20'h0500, 8, 1, 1'b1);

        for (int j = 0; j < 10; j++) begin
            int c;
            rb = AW'($urandom);
            c  = $urandom_range(0, 13);
            fill_mem(rb, c);
            run_job(rb, c, $urandom_range(0, 2), 1'b0);
        end

        // Abort during WAIT of the second word, then restart cleanly.
        fill_mem(20'h0200, 8);
        ready_mode = 0;
        done_cnt   = 0;
        @(posedge clk); #1;
        i_base_addr   = 20'h0200;
        i_pixel_count = 16'd8;
        i_start       = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        found   = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(negedge clk);
            if (o_sram_rd && o_sram_addr == 20'h0201) found = 1'b1;
        end
        check("abort_reached", 32'(found), 32'd1);
        @(posedge clk); #1;
        i_rst = 1'b1;
        @(posedge clk); #1;
        i_rst = 1'b0;
        @(negedge clk);
        check_outputs_zero("abort");
        repeat (4) @(negedge clk);
        check("abort_no_done", 32'(done_cnt), 32'd0);
        run_job(20'h0200, 8, 1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
